// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst controller: FSM state
// encoding, transfer direction codes and the DRAM page size used to split bursts.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } dma_state_e;

  localparam logic DIR_RD = 1'b0;  // DRAM -> buffer
  localparam logic DIR_WR = 1'b1;  // buffer -> DRAM

  localparam logic [31:0] BOUNDARY_BYTES = 32'd4096;

  // Words left before the next BOUNDARY_BYTES page starts (1..1024 for a word-aligned address).
  function automatic logic [31:0] words_to_boundary(input logic [31:0] addr);
    logic [31:0] offset;
    offset = addr & (BOUNDARY_BYTES - 32'd1);
    return (BOUNDARY_BYTES - offset) >> 2;
  endfunction

endpackage

// File: rtl/dma_burst_ctrl_if.sv
// Bus-side signals of the DMA burst controller: the burst request channel,
// the read beat channel and the write beat channel.
//
// Handshake rule (req_* and wdata_* channels): a transfer happens on a rising
// edge where valid and ready are both high. Once valid is raised it stays high,
// and its payload stays unchanged, until that transfer happens. Ready may
// change at any time and may depend on valid. The read beat channel
// (rdata_valid_i) has no ready: every beat presented is consumed.
interface dma_burst_ctrl_if #(
  parameter int MAX_BEATS = 16
);
  localparam int BW = $clog2(MAX_BEATS) + 1;

  logic          req_valid_o;
  logic          req_ready_i;
  logic [31:0]   req_addr_o;
  logic [BW-1:0] req_beats_o;
  logic          req_write_o;
  logic          rdata_valid_i;
  logic [31:0]   rdata_i;
  logic          wdata_valid_o;
  logic          wdata_ready_i;
  logic [31:0]   wdata_o;
  logic          wdata_last_o;

  modport master (
    output req_valid_o, req_addr_o, req_beats_o, req_write_o,
    output wdata_valid_o, wdata_o, wdata_last_o,
    input  req_ready_i, rdata_valid_i, rdata_i, wdata_ready_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, req_beats_o, req_write_o,
    input  wdata_valid_o, wdata_o, wdata_last_o,
    output req_ready_i, rdata_valid_i, rdata_i, wdata_ready_i
  );

endinterface

// File: rtl/dma_wr_skid.sv
// Write-beat holding register with one skid entry. The buffer has a one-cycle
// read latency, so a word already in flight must have somewhere to land when
// the bus stalls; the skid entry absorbs it. Output data only changes on a pop.
module dma_wr_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        ready,
  output logic        valid,
  output logic [31:0] data,
  output logic [1:0]  count
);

  logic        skid_valid;
  logic [31:0] skid_data;
  logic        pop;

  assign pop   = valid && ready;
  assign count = {1'b0, valid} + {1'b0, skid_valid};

  // Move words holding <- skid <- push, keeping arrival order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      data       <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!valid || pop) begin
      if (skid_valid) begin
        valid <= 1'b1;
        data  <= skid_data;
        if (push) skid_data <= push_data;
        else      skid_valid <= 1'b0;
      end else if (push) begin
        valid <= 1'b1;
        data  <= push_data;
      end else begin
        valid <= 1'b0;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= push_data;
    end
  end

endmodule

// File: rtl/dma_burst_ctrl.sv
// DMA burst controller: splits a byte-length transfer into bus bursts of at
// most MAX_BEATS 32-bit beats and moves data between DRAM and a local buffer.
// Optional macro DMA_4K_BOUNDARY_EN: when defined, no burst crosses a 4 KB
// address boundary.
module dma_burst_ctrl
  import dma_pkg::*;
#(
  parameter int MAX_BEATS = 16,
  parameter int BUF_AW    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [31:0]         dma_base_addr_i,
  input  logic [31:0]         dma_len_i,
  input  logic                dir_i,
  input  logic [BUF_AW-1:0]   buf_base_i,
  output logic                busy_o,
  output logic                dma_interrupt_o,
  dma_burst_ctrl_if.master    bus,
  output logic                buf_wr_en_o,
  output logic                buf_rd_en_o,
  output logic [BUF_AW-1:0]   buf_addr_o,
  output logic [31:0]         buf_wdata_o,
  input  logic [31:0]         buf_rdata_i,
  output dma_state_e          dbg_state
);

  localparam int BW = $clog2(MAX_BEATS) + 1;

  dma_state_e        state;
  logic [31:0]       addr, words;
  logic              dir, busy, irq, req_valid, rd_inflight;
  logic [BUF_AW-1:0] buf_addr;
  logic [BW-1:0]     beats, beat_cnt, fetch_cnt;

  logic [31:0] start_addr, start_words, next_addr, next_words, start_lim, next_lim;
  logic        rd_beat, wr_pop, last_beat, burst_end, space, skid_valid;
  logic [31:0] skid_data;
  logic [1:0]  occ;
  logic [2:0]  pending;

  // Burst size: remaining words clipped to MAX_BEATS and to the page limit.
  function automatic logic [BW-1:0] calc_beats(input logic [31:0] left, input logic [31:0] lim);
    logic [31:0] n;
    n = (left < 32'(MAX_BEATS)) ? left : 32'(MAX_BEATS);
    if (lim < n) n = lim;
    return n[BW-1:0];
  endfunction

  assign start_addr  = dma_base_addr_i & ~32'd3;
  assign start_words = {2'b00, dma_len_i[31:2]} + {31'd0, |dma_len_i[1:0]};
  assign next_addr   = addr + (32'(beats) << 2);
  assign next_words  = words - 32'(beats);

`ifdef DMA_4K_BOUNDARY_EN
  assign start_lim = words_to_boundary(start_addr);
  assign next_lim  = words_to_boundary(next_addr);
`else
  assign start_lim = '1;
  assign next_lim  = '1;
`endif

  assign rd_beat   = (state == DATA) && (dir == DIR_RD) && bus.rdata_valid_i;
  assign wr_pop    = skid_valid && bus.wdata_ready_i;
  assign last_beat = (beat_cnt == beats - 1'b1);
  assign burst_end = (rd_beat || wr_pop) && last_beat;

  // A buffer read may be issued only if its word is sure to find room next cycle.
  assign pending = {1'b0, occ} + {2'b00, rd_inflight};
  assign space   = (pending < 3'd2) || ((pending == 3'd2) && wr_pop);

  assign buf_rd_en_o = (state == DATA) && (dir == DIR_WR) && (fetch_cnt != beats) && space;
  assign buf_wr_en_o = rd_beat;
  assign buf_wdata_o = rd_beat ? bus.rdata_i : '0;
  assign buf_addr_o  = buf_addr;

  assign busy_o          = busy;
  assign dma_interrupt_o = irq;
  assign dbg_state       = state;

  assign bus.req_valid_o   = req_valid;
  assign bus.req_addr_o    = addr;
  assign bus.req_beats_o   = beats;
  assign bus.req_write_o   = dir;
  assign bus.wdata_valid_o = skid_valid;
  assign bus.wdata_o       = skid_data;
  assign bus.wdata_last_o  = skid_valid && (state == DATA) && (dir == DIR_WR) && last_beat;

  dma_wr_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_inflight),
    .push_data (buf_rdata_i),
    .ready     (bus.wdata_ready_i),
    .valid     (skid_valid),
    .data      (skid_data),
    .count     (occ)
  );

  // Transfer FSM: latch the job, issue bursts, move beats, pulse completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      words       <= '0;
      dir         <= 1'b0;
      busy        <= 1'b0;
      irq         <= 1'b0;
      req_valid   <= 1'b0;
      rd_inflight <= 1'b0;
      buf_addr    <= '0;
      beats       <= '0;
      beat_cnt    <= '0;
      fetch_cnt   <= '0;
    end else begin
      irq         <= 1'b0;
      rd_inflight <= buf_rd_en_o;
      case (state)
        IDLE: begin
          if (start_i) begin
            addr     <= start_addr;
            words    <= start_words;
            dir      <= dir_i;
            buf_addr <= buf_base_i;
            busy     <= 1'b1;
            if (start_words == 32'd0) begin
              state <= DONE;
            end else begin
              state     <= REQ;
              req_valid <= 1'b1;
              beats     <= calc_beats(start_words, start_lim);
            end
          end
        end
        REQ: begin
          if (bus.req_ready_i) begin
            req_valid <= 1'b0;
            beat_cnt  <= '0;
            fetch_cnt <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (rd_beat || buf_rd_en_o) buf_addr <= buf_addr + 1'b1;
          if (buf_rd_en_o)            fetch_cnt <= fetch_cnt + 1'b1;
          if (rd_beat || wr_pop)      beat_cnt <= beat_cnt + 1'b1;
          if (burst_end) begin
            addr  <= next_addr;
            words <= next_words;
            if (next_words != 32'd0) begin
              state     <= REQ;
              req_valid <= 1'b1;
              beats     <= calc_beats(next_words, next_lim);
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          irq   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_burst_ctrl.sv
// Bench for dma_burst_ctrl: a bus slave and buffer model drive the DUT, a
// reference model predicts bursts, buffer writes and write beats, and a
// monitor compares everything the DUT presents against those predictions.
`timescale 1ns/1ps
module tb_dma_burst_ctrl;
  import dma_pkg::*;

  localparam int MAX_BEATS = 16;
  localparam int BUF_AW    = 8;
  localparam int BW        = $clog2(MAX_BEATS) + 1;
  localparam int BI        = 32 + BW + 1;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic [31:0] dma_base_addr_i = '0;
  logic [31:0] dma_len_i = '0;
  logic dir_i = 1'b0;
  logic [BUF_AW-1:0] buf_base_i = '0;
  logic busy_o, dma_interrupt_o, buf_wr_en_o, buf_rd_en_o;
  logic [BUF_AW-1:0] buf_addr_o;
  logic [31:0] buf_wdata_o;
  logic [31:0] buf_rdata_i = '0;
  dma_state_e dbg_state;
  int cyc = 0;

  dma_burst_ctrl_if #(.MAX_BEATS(MAX_BEATS)) bus ();

  dma_burst_ctrl #(.MAX_BEATS(MAX_BEATS), .BUF_AW(BUF_AW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .dma_base_addr_i(dma_base_addr_i), .dma_len_i(dma_len_i), .dir_i(dir_i),
    .buf_base_i(buf_base_i), .busy_o(busy_o), .dma_interrupt_o(dma_interrupt_o),
    .bus(bus), .buf_wr_en_o(buf_wr_en_o), .buf_rd_en_o(buf_rd_en_o),
    .buf_addr_o(buf_addr_o), .buf_wdata_o(buf_wdata_o), .buf_rdata_i(buf_rdata_i),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [BI-1:0]        exp_burst_q[$];
  logic [BUF_AW+31:0]   exp_bufw_q[$];
  logic [32:0]          exp_wdata_q[$];
  logic [31:0]          rd_stim_q[$];
  logic [31:0]          mem [0:(1<<BUF_AW)-1];
  int rd_left = 0;
  int irq_count = 0;
  int bufw_seen = 0;
  int ready_mode = 2;  // 0 random, 1 toggle, 2 always high
  int n_checks = 0;
  int n_fail = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string name, logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
  endfunction

  // Reference model: split the job into bursts from the length/address rules.
  task automatic issue_model(input logic [31:0] addr, input logic [31:0] len,
                             input logic dir, input logic [BUF_AW-1:0] base);
    longint unsigned words, a, lim;
    int n, idx;
    logic [BUF_AW-1:0] b;
    logic [31:0] d;
    words = ({32'd0, len} + 64'd3) / 64'd4;
    a = {32'd0, addr[31:2], 2'b00};
    idx = 0;
    while (words > 0) begin
      n = (words > MAX_BEATS) ? MAX_BEATS : int'(words);
`ifdef DMA_4K_BOUNDARY_EN
      lim = (64'd4096 - (a % 64'd4096)) / 64'd4;
      if (lim < longint'(n)) n = int'(lim);
`else
      lim = 0;
`endif
      exp_burst_q.push_back({a[31:0], n[BW-1:0], dir});
      for (int i = 0; i < n; i++) begin
        b = base + BUF_AW'(idx);
        if (dir == DIR_RD) begin
          d = $urandom;
          rd_stim_q.push_back(d);
          exp_bufw_q.push_back({b, d});
        end else begin
          exp_wdata_q.push_back({(i == n - 1), mem[b]});
        end
        idx++;
      end
      a = (a + 64'd4 * longint'(n)) % 64'h1_0000_0000;
      words -= longint'(n);
    end
  endtask

  task automatic flush_model();
    exp_burst_q.delete();
    exp_bufw_q.delete();
    exp_wdata_q.delete();
    rd_stim_q.delete();
    rd_left = 0;
  endtask

  // ---------------- bus slave + buffer memory driver ----------------
  initial begin : slave
    logic rd_sel, prev_ready;
    logic [BUF_AW-1:0] rd_addr;
    bus.req_ready_i = 1'b0;
    bus.rdata_valid_i = 1'b0;
    bus.rdata_i = '0;
    bus.wdata_ready_i = 1'b0;
    for (int i = 0; i < (1 << BUF_AW); i++) mem[i] = $urandom;
    forever begin
      @(negedge clk);
      if (bus.req_valid_o && bus.req_ready_i && !bus.req_write_o) rd_left += int'(bus.req_beats_o);
      rd_sel = buf_rd_en_o;
      rd_addr = buf_addr_o;
      prev_ready = bus.wdata_ready_i;
      @(posedge clk);
      #1;
      bus.req_ready_i = ($urandom_range(0, 2) != 0);
      if (rd_left > 0 && $urandom_range(0, 3) != 0) begin
        bus.rdata_valid_i = 1'b1;
        bus.rdata_i = (rd_stim_q.size() > 0) ? rd_stim_q.pop_front() : $urandom;
        rd_left--;
      end else if (rd_left == 0 && $urandom_range(0, 4) == 0) begin
        bus.rdata_valid_i = 1'b1;  // stray beat, must be ignored
        bus.rdata_i = $urandom;
      end else begin
        bus.rdata_valid_i = 1'b0;
      end
      case (ready_mode)
        0: bus.wdata_ready_i = ($urandom_range(0, 1) != 0);
        1: bus.wdata_ready_i = ~prev_ready;
        default: bus.wdata_ready_i = 1'b1;
      endcase
      buf_rdata_i = rd_sel ? mem[rd_addr] : $urandom;
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [BI-1:0] cur, req_prev;
    logic req_wait, held_v, prev_last;
    logic [32:0] held_d, wcur, e33;
    logic [BUF_AW+31:0] bcur;
    int last_pop_cyc;
    req_wait = 1'b0;
    held_v = 1'b0;
    prev_last = 1'b1;
    last_pop_cyc = 0;
    req_prev = '0;
    held_d = '0;
    forever begin
      @(negedge clk);
      cur = {bus.req_addr_o, bus.req_beats_o, bus.req_write_o};
      if (bus.req_valid_o) begin
        if (req_wait) check("req_stable", 64'(cur), 64'(req_prev));
        if (bus.req_ready_i) begin
          if (exp_burst_q.size() == 0) fail_now("burst_unexpected", 64'(cur));
          else check("burst", 64'(cur), 64'(exp_burst_q.pop_front()));
        end
        req_wait = !bus.req_ready_i;
        req_prev = cur;
      end else begin
        req_wait = 1'b0;
      end
      if (buf_wr_en_o) begin
        bcur = {buf_addr_o, buf_wdata_o};
        if (exp_bufw_q.size() == 0) fail_now("bufw_unexpected", 64'(bcur));
        else check("buf_write", 64'(bcur), 64'(exp_bufw_q.pop_front()));
        mem[buf_addr_o] = buf_wdata_o;
        bufw_seen++;
      end
      wcur = {bus.wdata_last_o, bus.wdata_o};
      if (bus.wdata_valid_o && held_v) check("wdata_stable", 64'(wcur), 64'(held_d));
      if (bus.wdata_valid_o && bus.wdata_ready_i) begin
        if (exp_wdata_q.size() == 0) begin
          fail_now("wdata_unexpected", 64'(wcur));
        end else begin
          e33 = exp_wdata_q.pop_front();
          check("wdata_beat", 64'(wcur), 64'(e33));
          if (ready_mode == 2 && !prev_last) check("wr_throughput", 64'(cyc - last_pop_cyc), 64'd1);
          prev_last = e33[32];
          last_pop_cyc = cyc;
        end
      end
      held_v = bus.wdata_valid_o && !bus.wdata_ready_i;
      held_d = wcur;
      if (dma_interrupt_o) begin
        irq_count++;
        check("busy_at_irq", 64'(busy_o), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    flush_model();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, 64'(busy_o), 0);
    check({tag, "_irq"}, 64'(dma_interrupt_o), 0);
    check({tag, "_req"}, 64'({bus.req_valid_o, bus.req_addr_o, bus.req_beats_o, bus.req_write_o}), 0);
    check({tag, "_wdata"}, 64'({bus.wdata_valid_o, bus.wdata_last_o, bus.wdata_o}), 0);
    check({tag, "_buf"}, 64'({buf_wr_en_o, buf_rd_en_o, buf_addr_o, buf_wdata_o}), 0);
  endtask

  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] len, input logic dir,
                          input logic [BUF_AW-1:0] base, input int rmode, input bit poke);
    int irq0, t;
    ready_mode = rmode;
    issue_model(addr, len, dir, base);
    irq0 = irq_count;
    @(posedge clk);
    #2;
    start_i = 1'b1;
    dma_base_addr_i = addr;
    dma_len_i = len;
    dir_i = dir;
    buf_base_i = base;
    @(posedge clk);
    #2;
    start_i = 1'b0;
    dma_base_addr_i = $urandom;
    dma_len_i = $urandom;
    dir_i = ~dir;
    buf_base_i = BUF_AW'($urandom);
    if (poke) begin
      @(posedge clk);
      #2 start_i = 1'b1;  // must be ignored: transfer still busy
      @(posedge clk);
      #2 start_i = 1'b0;
    end
    t = 0;
    while (irq_count == irq0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (irq_count == irq0) begin
      fail_now("xfer_timeout", 64'(addr));
      pulse_reset();
    end else begin
      repeat (3) @(negedge clk);
      check("irq_once", 64'(irq_count - irq0), 64'd1);
      check("bursts_left", 64'(exp_burst_q.size()), 0);
      check("bufw_left", 64'(exp_bufw_q.size()), 0);
      check("wdata_left", 64'(exp_wdata_q.size()), 0);
      check("busy_after", 64'(busy_o), 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int irq0, t, seen0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed cases
    run_xfer(32'h0000_1000, 32'd40, DIR_RD, 8'h10, 2, 1'b0);
    run_xfer(32'h0000_2000, 32'd200, DIR_RD, 8'h20, 2, 1'b1);
    run_xfer(32'h0000_0FF0, 32'd64, DIR_RD, 8'h00, 2, 1'b0);
    run_xfer(32'h0000_4000, 32'd64, DIR_WR, 8'h40, 1, 1'b0);
    run_xfer(32'h0000_5004, 32'd200, DIR_WR, 8'hF8, 2, 1'b1);
    run_xfer(32'hFFFF_FFF0, 32'd64, DIR_RD, 8'hFC, 0, 1'b0);
    run_xfer(32'h0000_6003, 32'd13, DIR_RD, 8'h80, 0, 1'b0);

    // Zero length: no request, interrupt two cycles after start
    irq0 = irq_count;
    @(posedge clk);
    #2;
    start_i = 1'b1;
    dma_len_i = 32'd0;
    dma_base_addr_i = 32'h0000_7000;
    dir_i = DIR_RD;
    @(negedge clk);
    check("len0_busy_c0", 64'(busy_o), 0);
    @(posedge clk);
    #2 start_i = 1'b0;
    @(negedge clk);
    check("len0_c1", 64'({busy_o, dma_interrupt_o, bus.req_valid_o}), 64'b100);
    @(negedge clk);
    check("len0_c2", 64'({busy_o, dma_interrupt_o, bus.req_valid_o}), 64'b010);
    @(negedge clk);
    check("len0_c3", 64'(dma_interrupt_o), 0);
    check("len0_irqs", 64'(irq_count - irq0), 64'd1);

    // Reset in the middle of a 16-beat read
    ready_mode = 2;
    issue_model(32'h0000_3000, 32'd64, DIR_RD, 8'h30);
    irq0 = irq_count;
    seen0 = bufw_seen;
    @(posedge clk);
    #2;
    start_i = 1'b1;
    dma_base_addr_i = 32'h0000_3000;
    dma_len_i = 32'd64;
    dir_i = DIR_RD;
    buf_base_i = 8'h30;
    @(posedge clk);
    #2 start_i = 1'b0;
    t = 0;
    while (bufw_seen < seen0 + 4 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("abort_reached_beat5", 64'(bufw_seen - seen0 >= 4), 64'd1);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    flush_model();
    repeat (30) @(posedge clk);
    check("abort_no_irq", 64'(irq_count - irq0), 0);
    run_xfer(32'h0000_3000, 32'd64, DIR_RD, 8'h30, 0, 1'b0);

    // Randomised transfers
    for (int k = 0; k < 16; k++) begin
      logic [31:0] a, l;
      logic d;
      case ($urandom_range(0, 3))
        0: a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
        1: a = 32'h0000_0F00 + 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      l = 32'($urandom_range(0, 260));
      d = ($urandom_range(0, 1) != 0);
      run_xfer(a, l, d, BUF_AW'($urandom), $urandom_range(0, 2), (l != 0) && ($urandom_range(0, 1) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
